// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready byte channel among NUM_REQ requesters,
// with bounded bursts and a 2-entry registered output stage. Define ARB_STALL_CNT_EN to add stall_cnt_o.
module stream_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int SRC_W     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        i_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] i_data_i,
    output logic [NUM_REQ-1:0]        i_ready_o,
    input  logic                      e_ready_i,
    output logic                      e_valid_o,
    output logic [DATA_W-1:0]         e_data_o,
    output logic [SRC_W-1:0]          e_src_o
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt_o
`endif
);

    localparam int BW = 4;

    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [SRC_W-1:0]  main_src_q, main_src_d, skid_src_q, skid_src_d;
    logic [SRC_W-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic              owner_vld_q, owner_vld_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;

    logic              can_accept, accept, pop, sel_found;
    logic [SRC_W-1:0]  sel, scan_idx;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
    endfunction

    assign can_accept = (occ_q != 2'd2);
    assign e_valid_o  = (occ_q != 2'd0);
    assign e_data_o   = main_data_q;
    assign e_src_o    = main_src_q;
    assign pop        = e_valid_o & e_ready_i;
    assign accept     = can_accept & sel_found;

    // A live owner keeps the grant; otherwise scan from rr_ptr, nearest offset wins.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        scan_idx  = '0;
        if (owner_vld_q && i_valid_i[owner_q] && (burst_cnt_q < BW'(MAX_BURST))) begin
            sel_found = 1'b1;
            sel       = owner_q;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                scan_idx = SRC_W'((int'(rr_ptr_q) + i) % NUM_REQ);
                if (i_valid_i[scan_idx]) begin
                    sel_found = 1'b1;
                    sel       = scan_idx;
                end
            end
        end
    end

    always_comb begin
        i_ready_o = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            i_ready_o[k] = accept && (sel == SRC_W'(k));
            if (sel == SRC_W'(k)) sel_data = i_data_i[k*DATA_W +: DATA_W];
        end
    end

    // Ownership only moves when the output stage can take a beat.
    always_comb begin
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (can_accept) begin
            if (owner_vld_q && !i_valid_i[owner_q]) begin
                owner_vld_d = 1'b0;
                rr_ptr_d    = wrap_inc(owner_q);
            end
            if (accept) begin
                if (owner_vld_q && (sel == owner_q)) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    owner_d     = sel;
                    owner_vld_d = 1'b1;
                    burst_cnt_d = BW'(1);
                end
                if (burst_cnt_d == BW'(MAX_BURST)) begin
                    owner_vld_d = 1'b0;
                    rr_ptr_d    = wrap_inc(sel);
                end
            end
        end
    end

    always_comb begin
        occ_d       = occ_q;
        main_data_d = main_data_q;
        main_src_d  = main_src_q;
        skid_data_d = skid_data_q;
        skid_src_d  = skid_src_q;
        case ({accept, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    main_data_d = sel_data;
                    main_src_d  = sel;
                end else begin
                    skid_data_d = sel_data;
                    skid_src_d  = sel;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                main_data_d = skid_data_q;
                main_src_d  = skid_src_q;
                occ_d       = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    main_data_d = sel_data;
                    main_src_d  = sel;
                end else begin
                    main_data_d = skid_data_q;
                    main_src_d  = skid_src_q;
                    skid_data_d = sel_data;
                    skid_src_d  = sel;
                end
            end
            default: ;
        endcase
    end

`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (e_valid_o && !e_ready_i && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q       <= '0;
            main_data_q <= '0;
            main_src_q  <= '0;
            skid_data_q <= '0;
            skid_src_q  <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            occ_q       <= occ_d;
            main_data_q <= main_data_d;
            main_src_q  <= main_src_d;
            skid_data_q <= skid_data_d;
            skid_src_q  <= skid_src_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule
